// File: rtl/control_pipe_if.sv
// Bundle of ID-stage inputs and per-stage control outputs for control_pipe.
// The master drives the ID instruction fields and pipeline controls; the slave returns the stage bundles.
interface control_pipe_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [6:0]            id_opcode;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  stall_ext;
  logic                  flush;

  logic                  hazard_stall;
  logic                  ex_branch;
  logic                  ex_jump;
  logic                  ex_memread;
  logic                  ex_memwrite;
  logic                  ex_alusrc;
  logic                  ex_regwrite;
  logic [1:0]            ex_aluop;
  logic                  ex_asel_pc;
  logic [1:0]            ex_wbsel;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_memread;
  logic                  mem_memwrite;
  logic                  mem_regwrite;
  logic [1:0]            mem_wbsel;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  wb_regwrite;
  logic [1:0]            wb_wbsel;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  illegal_op;
  logic [CNT_W-1:0]      hazard_cnt;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, stall_ext, flush,
    input  hazard_stall,
    input  ex_branch, ex_jump, ex_memread, ex_memwrite, ex_alusrc, ex_regwrite,
    input  ex_aluop, ex_asel_pc, ex_wbsel, ex_rd,
    input  mem_memread, mem_memwrite, mem_regwrite, mem_wbsel, mem_rd,
    input  wb_regwrite, wb_wbsel, wb_rd,
    input  illegal_op, hazard_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, stall_ext, flush,
    output hazard_stall,
    output ex_branch, ex_jump, ex_memread, ex_memwrite, ex_alusrc, ex_regwrite,
    output ex_aluop, ex_asel_pc, ex_wbsel, ex_rd,
    output mem_memread, mem_memwrite, mem_regwrite, mem_wbsel, mem_rd,
    output wb_regwrite, wb_wbsel, wb_rd,
    output illegal_op, hazard_cnt
  );
endinterface

// File: rtl/control_pipe.sv
// Pipelined RV32I main decoder: decodes in ID and carries control through ID/EX, EX/MEM and MEM/WB,
// with load-use stall detection, flush, external freeze, illegal-opcode trap and a saturating stall counter.
module control_pipe #(
  parameter int REG_ADDR_W    = 5,
  parameter bit SUPPORT_JALR  = 1'b1,
  parameter bit SUPPORT_AUIPC = 1'b1,
  parameter int CNT_W         = 16
) (
  input logic        clk,
  input logic        rst_n,
  control_pipe_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic                  branch;
    logic                  jump;
    logic                  memread;
    logic                  memwrite;
    logic                  alusrc;
    logic                  regwrite;
    logic [1:0]            aluop;
    logic                  asel_pc;
    logic [1:0]            wbsel;
    logic [REG_ADDR_W-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic                  memread;
    logic                  memwrite;
    logic                  regwrite;
    logic [1:0]            wbsel;
    logic [REG_ADDR_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic                  regwrite;
    logic [1:0]            wbsel;
    logic [REG_ADDR_W-1:0] rd;
  } mem_wb_t;

  id_ex_t           dec;
  id_ex_t           id_ex;
  ex_mem_t          ex_mem;
  mem_wb_t          mem_wb;
  logic             legal;
  logic             rs1_used;
  logic             rs2_used;
  logic             hazard;
  logic             illegal;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    dec      = '0;
    legal    = 1'b1;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    dec.rd   = bus.id_rd;
    case (bus.id_opcode)
      OP_R: begin
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b10;
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
      OP_I: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = 2'b11;
        rs1_used     = 1'b1;
      end
      OP_LOAD: begin
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.alusrc   = 1'b1;
        dec.wbsel    = 2'b01;
        rs1_used     = 1'b1;
      end
      OP_STORE: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
      OP_BR: begin
        dec.branch = 1'b1;
        dec.aluop  = 2'b01;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
      end
      OP_LUI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OP_JAL: begin
        dec.regwrite = 1'b1;
        dec.jump     = 1'b1;
        dec.wbsel    = 2'b10;
      end
      OP_JALR: begin
        if (SUPPORT_JALR) begin
          dec.regwrite = 1'b1;
          dec.jump     = 1'b1;
          dec.alusrc   = 1'b1;
          dec.wbsel    = 2'b10;
          rs1_used     = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_AUIPC: begin
        if (SUPPORT_AUIPC) begin
          dec.regwrite = 1'b1;
          dec.alusrc   = 1'b1;
          dec.asel_pc  = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  // A taken branch kills the dependent instruction anyway, so it never needs a stall.
  assign hazard = bus.id_valid & id_ex.memread & (id_ex.rd != '0) &
                  ((rs1_used & (bus.id_rs1 == id_ex.rd)) |
                   (rs2_used & (bus.id_rs2 == id_ex.rd))) & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
      cnt    <= '0;
    end else if (!bus.stall_ext) begin
      ex_mem.memread  <= id_ex.memread;
      ex_mem.memwrite <= id_ex.memwrite;
      ex_mem.regwrite <= id_ex.regwrite;
      ex_mem.wbsel    <= id_ex.wbsel;
      ex_mem.rd       <= id_ex.rd;
      mem_wb.regwrite <= ex_mem.regwrite;
      mem_wb.wbsel    <= ex_mem.wbsel;
      mem_wb.rd       <= ex_mem.rd;
      if (bus.flush || hazard || !bus.id_valid || !legal)
        id_ex <= '0;
      else
        id_ex <= dec;
      if (hazard && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal <= 1'b0;
    else if (bus.id_valid && !legal)
      illegal <= 1'b1;
  end

  assign bus.hazard_stall = hazard;
  assign bus.ex_branch    = id_ex.branch;
  assign bus.ex_jump      = id_ex.jump;
  assign bus.ex_memread   = id_ex.memread;
  assign bus.ex_memwrite  = id_ex.memwrite;
  assign bus.ex_alusrc    = id_ex.alusrc;
  assign bus.ex_regwrite  = id_ex.regwrite;
  assign bus.ex_aluop     = id_ex.aluop;
  assign bus.ex_asel_pc   = id_ex.asel_pc;
  assign bus.ex_wbsel     = id_ex.wbsel;
  assign bus.ex_rd        = id_ex.rd;
  assign bus.mem_memread  = ex_mem.memread;
  assign bus.mem_memwrite = ex_mem.memwrite;
  assign bus.mem_regwrite = ex_mem.regwrite;
  assign bus.mem_wbsel    = ex_mem.wbsel;
  assign bus.mem_rd       = ex_mem.rd;
  assign bus.wb_regwrite  = mem_wb.regwrite;
  assign bus.wb_wbsel     = mem_wb.wbsel;
  assign bus.wb_rd        = mem_wb.rd;
  assign bus.illegal_op   = illegal;
  assign bus.hazard_cnt   = cnt;
endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: default build plus a build with JALR disabled and a 2-bit stall counter.
module tb_control_pipe;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_ext, flush;

  int checks = 0;
  int failures = 0;

  logic [6:0]  sweep_op  [9];
  logic [10:0] sweep_ctl [9];

  always #5 clk = ~clk;

  control_pipe_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();
  control_pipe_if #(.REG_ADDR_W(5), .CNT_W(2))  bus2 ();

  assign bus.id_valid   = id_valid;
  assign bus.id_opcode  = id_opcode;
  assign bus.id_rs1     = id_rs1;
  assign bus.id_rs2     = id_rs2;
  assign bus.id_rd      = id_rd;
  assign bus.stall_ext  = stall_ext;
  assign bus.flush      = flush;
  assign bus2.id_valid  = id_valid;
  assign bus2.id_opcode = id_opcode;
  assign bus2.id_rs1    = id_rs1;
  assign bus2.id_rs2    = id_rs2;
  assign bus2.id_rd     = id_rd;
  assign bus2.stall_ext = stall_ext;
  assign bus2.flush     = flush;

  control_pipe #(.REG_ADDR_W(5), .SUPPORT_JALR(1'b1), .SUPPORT_AUIPC(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  control_pipe #(.REG_ADDR_W(5), .SUPPORT_JALR(1'b0), .SUPPORT_AUIPC(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  // {branch, jump, memread, memwrite, alusrc, regwrite, aluop, asel_pc, wbsel}
  logic [10:0] ex_ctl;
  logic [9:0]  mem_pk;
  logic [7:0]  wb_pk;
  assign ex_ctl = {bus.ex_branch, bus.ex_jump, bus.ex_memread, bus.ex_memwrite, bus.ex_alusrc,
                   bus.ex_regwrite, bus.ex_aluop, bus.ex_asel_pc, bus.ex_wbsel};
  assign mem_pk = {bus.mem_memread, bus.mem_memwrite, bus.mem_regwrite, bus.mem_wbsel, bus.mem_rd};
  assign wb_pk  = {bus.wb_regwrite, bus.wb_wbsel, bus.wb_rd};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] d,
                               input logic se, input logic fl);
    id_valid  = v;
    id_opcode = op;
    id_rs1    = r1;
    id_rs2    = r2;
    id_rd     = d;
    stall_ext = se;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sweep_op[0] = 7'b0110011; sweep_ctl[0] = 11'b00000110000;
    sweep_op[1] = 7'b0010011; sweep_ctl[1] = 11'b00001111000;
    sweep_op[2] = 7'b0000011; sweep_ctl[2] = 11'b00101100001;
    sweep_op[3] = 7'b0100011; sweep_ctl[3] = 11'b00011000000;
    sweep_op[4] = 7'b1100011; sweep_ctl[4] = 11'b10000001000;
    sweep_op[5] = 7'b0110111; sweep_ctl[5] = 11'b00001100000;
    sweep_op[6] = 7'b1101111; sweep_ctl[6] = 11'b01000100010;
    sweep_op[7] = 7'b1100111; sweep_ctl[7] = 11'b01001100010;
    sweep_op[8] = 7'b0010111; sweep_ctl[8] = 11'b00001100100;

    applyStimulus(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_ex", {21'd0, ex_ctl}, 32'd0);
    checkOutput("reset_stage_rd", {17'd0, bus.ex_rd, bus.mem_rd, bus.wb_rd}, 32'd0);
    checkOutput("reset_cnt_illegal", {15'd0, bus.illegal_op, bus.hazard_cnt}, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Decode sweep: rs fields are x0 so no hazard can trigger.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, sweep_op[i], 5'd0, 5'd0, 5'(i + 1), 1'b0, 1'b0);
      step();
      checkOutput($sformatf("sweep_ex_ctl_%0d", i), {21'd0, ex_ctl}, {21'd0, sweep_ctl[i]});
      checkOutput($sformatf("sweep_ex_rd_%0d", i), {27'd0, bus.ex_rd}, 32'(i + 1));
      if (i >= 1)
        checkOutput($sformatf("sweep_mem_%0d", i), {22'd0, mem_pk},
                    {22'd0, sweep_ctl[i-1][8], sweep_ctl[i-1][7], sweep_ctl[i-1][5],
                     sweep_ctl[i-1][1:0], 5'(i)});
      if (i >= 2)
        checkOutput($sformatf("sweep_wb_%0d", i), {24'd0, wb_pk},
                    {24'd0, sweep_ctl[i-2][5], sweep_ctl[i-2][1:0], 5'(i - 1)});
    end
    checkOutput("sweep_no_illegal", {31'd0, bus.illegal_op}, 32'd0);
    checkOutput("jalr_disabled_illegal", {31'd0, bus2.illegal_op}, 32'd1);

    applyStimulus(1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    checkOutput("idle_bubble", {21'd0, ex_ctl}, 32'd0);

    // Load-use on x5: exactly one stall cycle.
    applyStimulus(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, OP_R, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0);
    #1;
    checkOutput("lu_stall_on", {31'd0, bus.hazard_stall}, 32'd1);
    step();
    checkOutput("lu_bubble", {21'd0, ex_ctl}, 32'd0);
    checkOutput("lu_cnt", {16'd0, bus.hazard_cnt}, 32'd1);
    checkOutput("lu_stall_off", {31'd0, bus.hazard_stall}, 32'd0);
    step();
    checkOutput("lu_add_ex", {21'd0, ex_ctl}, 32'b00000110000);
    checkOutput("lu_add_rd", {27'd0, bus.ex_rd}, 32'd6);

    // Load into x0 never stalls.
    applyStimulus(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, OP_R, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0);
    #1;
    checkOutput("lu_x0_no_stall", {31'd0, bus.hazard_stall}, 32'd0);
    step();
    checkOutput("lu_x0_add_ex", {21'd0, ex_ctl}, 32'b00000110000);

    // Freeze with flush pending, then release while flush is still held.
    applyStimulus(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, OP_R, 5'd7, 5'd0, 5'd9, 1'b1, 1'b1);
    #1;
    checkOutput("flush_masks_hazard", {31'd0, bus.hazard_stall}, 32'd0);
    for (int k = 0; k < 3; k++) step();
    checkOutput("freeze_ex", {16'd0, ex_ctl, bus.ex_rd}, {16'd0, 11'b00101100001, 5'd7});
    checkOutput("freeze_mem", {22'd0, mem_pk}, {22'd0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd8});
    checkOutput("freeze_wb", {24'd0, wb_pk}, {24'd0, 1'b1, 2'b01, 5'd0});
    checkOutput("freeze_cnt", {16'd0, bus.hazard_cnt}, 32'd1);
    applyStimulus(1'b1, OP_R, 5'd7, 5'd0, 5'd9, 1'b0, 1'b1);
    step();
    checkOutput("release_flush_bubble", {21'd0, ex_ctl}, 32'd0);
    checkOutput("release_mem", {22'd0, mem_pk}, {22'd0, 1'b1, 1'b0, 1'b1, 2'b01, 5'd7});
    checkOutput("release_wb", {24'd0, wb_pk}, {24'd0, 1'b1, 2'b00, 5'd8});
    checkOutput("release_cnt", {16'd0, bus.hazard_cnt}, 32'd1);

    // Illegal opcode trapping.
    applyStimulus(1'b0, OP_BAD, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    step();
    checkOutput("bad_invalid_no_trap", {31'd0, bus.illegal_op}, 32'd0);
    applyStimulus(1'b1, OP_BAD, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    step();
    checkOutput("bad_bubble", {16'd0, ex_ctl, bus.ex_rd}, 32'd0);
    checkOutput("bad_trap", {31'd0, bus.illegal_op}, 32'd1);
    applyStimulus(1'b1, OP_R, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
    step();
    step();
    checkOutput("bad_trap_sticky", {31'd0, bus.illegal_op}, 32'd1);

    // Asynchronous reset mid-stream, away from any clock edge.
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_ex", {16'd0, ex_ctl, bus.ex_rd}, 32'd0);
    checkOutput("midreset_mem_wb", {14'd0, mem_pk, wb_pk}, 32'd0);
    checkOutput("midreset_flags", {15'd0, bus.illegal_op, bus.hazard_cnt}, 32'd0);
    checkOutput("midreset_dut2_flag", {31'd0, bus2.illegal_op}, 32'd0);
    applyStimulus(1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    // Five load-use stalls: 2-bit counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, OP_R, 5'd0, 5'd3, 5'd4, 1'b0, 1'b0);
      step();
      step();
    end
    checkOutput("sat_cnt_w2", {30'd0, bus2.hazard_cnt}, 32'd3);
    checkOutput("sat_cnt_w16", {16'd0, bus.hazard_cnt}, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
